pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 imem_resp  in  1  instruction memory response for the current fetch.
REQ-004 dmem_read_req, dmem_write_req  in  1 each  MEM stage access request, from the EX/MEM control word.
REQ-005 dmem_resp  in  1  data memory response.
REQ-006 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-007 id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads the matching source register.
REQ-008 ex_is_load  in  1  ID/EX holds a load; ex_rd  in  5  its destination register.
REQ-009 ex_redirect  in  1  EX resolved a taken branch or jump.
REQ-010 imem_read  out  1  fetch request; dmem_read, dmem_write  out  1 each  gated data requests.
REQ-011 pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  out  1 each  stage register loads.
REQ-012 if_id_clear, id_ex_clear, ex_mem_clear  out  1 each  stage register clears.
REQ-013 stall_cycles, bubble_count, flush_count  out  32 each  performance counters.

Function
REQ-014 Three-state FSM: RUN (no response held), HOLD_I (imem response held, waiting on dmem), HOLD_D (dmem response held, waiting on imem).
REQ-015 i_ok = imem_resp or state==HOLD_I.
REQ-016 d_ok = neither dmem request asserted, or dmem_resp, or state==HOLD_D.
REQ-017 adv = i_ok and d_ok; adv is combinational, with zero-cycle latency from response to load.
REQ-018 RUN -> HOLD_I when imem_resp and not d_ok; RUN -> HOLD_D when dmem_resp and not i_ok.
REQ-019 HOLD_I -> RUN and HOLD_D -> RUN on adv; otherwise the state holds.
REQ-020 imem_read = 1 except in HOLD_I.
REQ-021 dmem_read = dmem_read_req and dmem_write = dmem_write_req, except in HOLD_D, where both are 0 so no access is reissued.
REQ-022 If not adv: all load and clear outputs are 0.
REQ-023 load_use = ex_is_load and ex_rd!=0 and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)).
REQ-024 adv and ex_redirect: pc_load=1, if_id_clear=1, id_ex_clear=1, ex_mem_load=1, mem_wb_load=1, flush_count += 1.
REQ-025 ex_redirect has priority over load_use when both are true.
REQ-026 adv and load_use and not ex_redirect: pc_load=0, if_id_load=0, id_ex_clear=1, ex_mem_load=1, mem_wb_load=1, bubble_count += 1.
REQ-027 adv otherwise: all five load outputs are 1 and all clear outputs are 0.
REQ-028 A clear is never asserted on the same cycle as a load of the same register.
REQ-029 ex_mem_clear is asserted only during reset.
REQ-030 stall_cycles += 1 on every cycle with rst low and adv low.
REQ-031 All counters are 32 bits and wrap from 0xFFFFFFFF to 0 without a flag.
REQ-032 ex_redirect asserted while not adv is ignored until adv; EX holds it stable, because id_ex_load=0.

Reset
REQ-033 While rst is high: state=RUN and all counters are 0.
REQ-034 While rst is high: all load outputs are 0 and if_id_clear = id_ex_clear = ex_mem_clear = 1.
REQ-035 While rst is high: imem_read, dmem_read and dmem_write are 0.
REQ-036 Reset asserted mid-stall (HOLD_I or HOLD_D) discards the held response; the first post-reset fetch is reissued.

Structure
REQ-037 The FSM state enum pipe_ctrl_state_t {RUN, HOLD_I, HOLD_D} is defined in rv32i_types.
REQ-038 The 32-bit counter width constant is defined in rv32i_types.
REQ-039 Load-use detection is a combinational sub-module load_use_detect, instantiated once.
REQ-040 The FSM, gating and counters reside in pipeline_ctrl; target 150-300 lines total.

Verification
REQ-041 No dmem request, imem_resp=1 every cycle -> all loads 1 each cycle, stall_cycles stays 0.
REQ-042 dmem_read_req=1, imem_resp in cycle 1, dmem_resp in cycle 4:
- state HOLD_I from cycle 2;
- imem_read=0 in cycles 2-4;
- single advance in cycle 4;
- stall_cycles=3.
REQ-043 Responses in reverse order (dmem_resp cycle 1, imem_resp cycle 3):
- state HOLD_D;
- dmem_read=0 in cycles 2-3;
- advance in cycle 3.
REQ-044 ex_is_load=1, ex_rd=5, id_rs2=5, id_uses_rs2=1, adv -> id_ex_clear=1, pc_load=0, if_id_load=0, bubble_count=1.
REQ-045 Same as REQ-044 plus ex_redirect=1 -> if_id_clear=1, id_ex_clear=1, pc_load=1, flush_count=1, bubble_count=0.
REQ-046 Pulse rst in HOLD_I with stall_cycles=7 -> state RUN, counters 0, all three clears 1 while rst high.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types and constants for the pipeline control slice.
package rv32i_types;

   localparam int CNT_W = 32;

   typedef enum logic [1:0] {
      RUN,
      HOLD_I,
      HOLD_D
   } pipe_ctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX.
module load_use_detect (
   input  logic       ex_is_load_i,
   input  logic [4:0] ex_rd_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       id_uses_rs1_i,
   input  logic       id_uses_rs2_i,
   output logic       load_use_o
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit    = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
   assign rs2_hit    = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
   // x0 never carries a real dependency
   assign load_use_o = ex_is_load_i && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: memory handshake FSM, stage register gating
// and performance counters.
module pipeline_ctrl
   import rv32i_types::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             imem_resp,
   input  logic             dmem_read_req,
   input  logic             dmem_write_req,
   input  logic             dmem_resp,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_is_load,
   input  logic [4:0]       ex_rd,
   input  logic             ex_redirect,
   output logic             imem_read,
   output logic             dmem_read,
   output logic             dmem_write,
   output logic             pc_load,
   output logic             if_id_load,
   output logic             id_ex_load,
   output logic             ex_mem_load,
   output logic             mem_wb_load,
   output logic             if_id_clear,
   output logic             id_ex_clear,
   output logic             ex_mem_clear,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] bubble_count,
   output logic [CNT_W-1:0] flush_count
);

   pipe_ctrl_state_t state_q, state_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] bubble_q, bubble_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   logic i_ok, d_ok, adv, load_use;

   load_use_detect u_load_use_detect (
      .ex_is_load_i  (ex_is_load),
      .ex_rd_i       (ex_rd),
      .id_rs1_i      (id_rs1),
      .id_rs2_i      (id_rs2),
      .id_uses_rs1_i (id_uses_rs1),
      .id_uses_rs2_i (id_uses_rs2),
      .load_use_o    (load_use)
   );

   assign i_ok = imem_resp || (state_q == HOLD_I);
   assign d_ok = !(dmem_read_req || dmem_write_req) || dmem_resp || (state_q == HOLD_D);
   assign adv  = i_ok && d_ok;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (imem_resp && !d_ok)
               state_d = HOLD_I;
            else if (dmem_resp && !i_ok)
               state_d = HOLD_D;
         end
         HOLD_I, HOLD_D: begin
            if (adv)
               state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      imem_read    = 1'b0;
      dmem_read    = 1'b0;
      dmem_write   = 1'b0;
      pc_load      = 1'b0;
      if_id_load   = 1'b0;
      id_ex_load   = 1'b0;
      ex_mem_load  = 1'b0;
      mem_wb_load  = 1'b0;
      if_id_clear  = 1'b0;
      id_ex_clear  = 1'b0;
      ex_mem_clear = 1'b0;
      if (rst) begin
         if_id_clear  = 1'b1;
         id_ex_clear  = 1'b1;
         ex_mem_clear = 1'b1;
      end else begin
         imem_read  = (state_q != HOLD_I);
         // a held data response must not trigger a second access
         dmem_read  = dmem_read_req && (state_q != HOLD_D);
         dmem_write = dmem_write_req && (state_q != HOLD_D);
         if (adv) begin
            if (ex_redirect) begin
               pc_load     = 1'b1;
               if_id_clear = 1'b1;
               id_ex_clear = 1'b1;
               ex_mem_load = 1'b1;
               mem_wb_load = 1'b1;
            end else if (load_use) begin
               id_ex_clear = 1'b1;
               ex_mem_load = 1'b1;
               mem_wb_load = 1'b1;
            end else begin
               pc_load     = 1'b1;
               if_id_load  = 1'b1;
               id_ex_load  = 1'b1;
               ex_mem_load = 1'b1;
               mem_wb_load = 1'b1;
            end
         end
      end
   end

   always_comb begin
      stall_d  = adv ? stall_q : stall_q + CNT_W'(1);
      bubble_d = (adv && load_use && !ex_redirect) ? bubble_q + CNT_W'(1) : bubble_q;
      flush_d  = (adv && ex_redirect) ? flush_q + CNT_W'(1) : flush_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= RUN;
         stall_q  <= '0;
         bubble_q <= '0;
         flush_q  <= '0;
      end else begin
         state_q  <= state_d;
         stall_q  <= stall_d;
         bubble_q <= bubble_d;
         flush_q  <= flush_d;
      end
   end

   assign stall_cycles = stall_q;
   assign bubble_count = bubble_q;
   assign flush_count  = flush_q;

endmodule
